// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell reused over N_BITS cycles.
// Operands shift out LSB-first; the sum shifts in from the MSB side.
module serial_adder_ctrl #(
   parameter int N_BITS = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [N_BITS-1:0] i_a,
   input  logic [N_BITS-1:0] i_b,
   input  logic              i_carry_in,
   output logic              o_busy,
   output logic              o_done,
   output logic [N_BITS-1:0] o_s,
   output logic              o_carry_out
);

   localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q;
   logic [N_BITS-1:0] a_q;
   logic [N_BITS-1:0] b_q;
   logic              c_q;
   logic [N_BITS-1:0] psum_q;
   logic [CW-1:0]     cnt_q;
   logic [N_BITS-1:0] s_q;
   logic              co_q;
   logic              done_q;
   logic              busy_q;

   logic              sum_d;
   logic              carry_d;
   logic [N_BITS-1:0] psum_d;
   logic              last_d;

   // Single full-adder cell plus the partial sum after this cycle's shift.
   always_comb begin
      sum_d   = a_q[0] ^ b_q[0] ^ c_q;
      carry_d = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
      psum_d  = psum_q >> 1;
      psum_d[N_BITS-1] = sum_d;
      last_d  = (cnt_q == LAST);
   end

   // Control FSM with the serial datapath and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         psum_q  <= '0;
         cnt_q   <= '0;
         s_q     <= '0;
         co_q    <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (i_start) begin
                  a_q     <= i_a;
                  b_q     <= i_b;
                  c_q     <= i_carry_in;
                  psum_q  <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               psum_q <= psum_d;
               c_q    <= carry_d;
               a_q    <= a_q >> 1;
               b_q    <= b_q >> 1;
               cnt_q  <= cnt_q + CW'(1);
               if (last_d) begin
                  s_q     <= psum_d;
                  co_q    <= carry_d;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_s         = s_q;
   assign o_carry_out = co_q;

endmodule
